// File: rtl/sap_pkg.sv
// Shared definitions for the SAP microprogram sequencer: opcodes,
// control-word bit positions and masks, fixed control words, state encoding.
package sap_pkg;

    // Opcodes (IR high nibble)
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JN  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit indices; names ending in _N are active-low
    localparam int CW_CP   = 15;
    localparam int CW_EP   = 14;
    localparam int CW_LM_N = 13;
    localparam int CW_CE_N = 12;
    localparam int CW_LI_N = 11;
    localparam int CW_EI_N = 10;
    localparam int CW_LA_N = 9;
    localparam int CW_EA   = 8;
    localparam int CW_SU   = 7;
    localparam int CW_EU   = 6;
    localparam int CW_LB_N = 5;
    localparam int CW_LO_N = 4;
    localparam int CW_LP_N = 3;
    localparam int CW_LF_N = 2;
    localparam int CW_WE_N = 1;
    localparam int CW_HLT  = 0;

    // Every strobe sits at its inactive level in CW_NOP, so asserting a
    // strobe is always an XOR of its mask into CW_NOP, whatever its polarity.
    localparam logic [15:0] M_CP   = 16'h1 << CW_CP;
    localparam logic [15:0] M_EP   = 16'h1 << CW_EP;
    localparam logic [15:0] M_LM_N = 16'h1 << CW_LM_N;
    localparam logic [15:0] M_CE_N = 16'h1 << CW_CE_N;
    localparam logic [15:0] M_LI_N = 16'h1 << CW_LI_N;
    localparam logic [15:0] M_EI_N = 16'h1 << CW_EI_N;
    localparam logic [15:0] M_LA_N = 16'h1 << CW_LA_N;
    localparam logic [15:0] M_EA   = 16'h1 << CW_EA;
    localparam logic [15:0] M_SU   = 16'h1 << CW_SU;
    localparam logic [15:0] M_EU   = 16'h1 << CW_EU;
    localparam logic [15:0] M_LB_N = 16'h1 << CW_LB_N;
    localparam logic [15:0] M_LO_N = 16'h1 << CW_LO_N;
    localparam logic [15:0] M_LP_N = 16'h1 << CW_LP_N;
    localparam logic [15:0] M_LF_N = 16'h1 << CW_LF_N;
    localparam logic [15:0] M_WE_N = 16'h1 << CW_WE_N;
    localparam logic [15:0] M_HLT  = 16'h1 << CW_HLT;

    localparam logic [15:0] CW_NOP  = 16'h3E3E;
    localparam logic [15:0] CW_HALT = CW_NOP ^ M_HLT;

    // T1..T8 encode their own T-state index in the low three bits
    typedef enum logic [3:0] {
        ST_T1     = 4'd0,
        ST_T2     = 4'd1,
        ST_T3     = 4'd2,
        ST_T4     = 4'd3,
        ST_T5     = 4'd4,
        ST_T6     = 4'd5,
        ST_T7     = 4'd6,
        ST_T8     = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

endpackage

// File: rtl/sap_if.sv
// Sequencer-to-datapath bundle. The master side is the sequencer: it takes
// the IR opcode and flags and drives the strobes and status. There is no
// handshake here; all signals are level-valid every cycle, sampled on the
// rising clock edge by whoever consumes them.
interface sap_if;
    logic [3:0]  instruction;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] control_word;
    logic [2:0]  t_state;
    logic        instr_done;
    logic        halted;
    logic        illegal_op;

    modport master (
        input  instruction, flag_z, flag_n,
        output control_word, t_state, instr_done, halted, illegal_op
    );

    modport slave (
        output instruction, flag_z, flag_n,
        input  control_word, t_state, instr_done, halted, illegal_op
    );
endinterface

// File: rtl/sap_microcode.sv
// Combinational microcode ROM: maps (opcode, T-state, flags) to the control
// word, plus markers for the last active T-state, undefined opcodes and HLT.
module sap_microcode
    import sap_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  t_idx,
    input  logic        flag_z,
    input  logic        flag_n,
    output logic [15:0] control_word,
    output logic        last,
    output logic        illegal,
    output logic        halt
);

    // Fetch for T1..T3, opcode-specific execute for T4..T6, NOP beyond that
    always_comb begin
        control_word = CW_NOP;
        last         = 1'b0;
        illegal      = 1'b0;
        halt         = 1'b0;
        case (t_idx)
            3'd0: control_word = CW_NOP ^ (M_EP | M_LM_N);
            3'd1: control_word = CW_NOP ^ M_CP;
            3'd2: control_word = CW_NOP ^ (M_CE_N | M_LI_N);
            3'd3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        control_word = CW_NOP ^ (M_EI_N | M_LM_N);
                    OP_LDI: begin
                        control_word = CW_NOP ^ (M_EI_N | M_LA_N | M_LF_N);
                        last         = 1'b1;
                    end
                    OP_JMP: begin
                        control_word = CW_NOP ^ (M_EI_N | M_LP_N);
                        last         = 1'b1;
                    end
                    OP_JZ: begin
                        if (flag_z) control_word = CW_NOP ^ (M_EI_N | M_LP_N);
                        last = 1'b1;
                    end
                    OP_JN: begin
                        if (flag_n) control_word = CW_NOP ^ (M_EI_N | M_LP_N);
                        last = 1'b1;
                    end
                    OP_OUT: begin
                        control_word = CW_NOP ^ (M_EA | M_LO_N);
                        last         = 1'b1;
                    end
                    OP_HLT: begin
                        control_word = CW_HALT;
                        halt         = 1'b1;
                    end
                    default: begin
                        illegal = 1'b1;
                        last    = 1'b1;
                    end
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_LDA: begin
                        control_word = CW_NOP ^ (M_CE_N | M_LA_N | M_LF_N);
                        last         = 1'b1;
                    end
                    OP_ADD, OP_SUB:
                        control_word = CW_NOP ^ (M_CE_N | M_LB_N);
                    OP_STA: begin
                        control_word = CW_NOP ^ (M_EA | M_WE_N);
                        last         = 1'b1;
                    end
                    default: control_word = CW_NOP;
                endcase
            end
            3'd5: begin
                case (opcode)
                    OP_ADD: begin
                        control_word = CW_NOP ^ (M_EU | M_LA_N | M_LF_N);
                        last         = 1'b1;
                    end
                    OP_SUB: begin
                        control_word = CW_NOP ^ (M_SU | M_EU | M_LA_N | M_LF_N);
                        last         = 1'b1;
                    end
                    default: control_word = CW_NOP;
                endcase
            end
            default: control_word = CW_NOP;
        endcase
    end

endmodule

// File: rtl/sap_sequencer.sv
// SAP microprogram sequencer: T-state register, early-end or NOP padding,
// halt latch and reset forcing around the combinational microcode.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter bit EARLY_END = 1'b1,
    parameter int T_MAX     = 6
) (
    input  logic clock,
    input  logic reset,
    sap_if.master bus
);

    if (T_MAX < 6 || T_MAX > 8) begin : g_bad_t_max
        $error("sap_sequencer: T_MAX must be in 6..8");
    end

    localparam logic [2:0] T_LAST = 3'(T_MAX - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  t_idx;
    logic [15:0] uc_cw;
    logic        uc_last;
    logic        uc_illegal;
    logic        uc_halt;
    logic        done;

    assign t_idx = state[2:0];

    sap_microcode u_microcode (
        .opcode       (bus.instruction),
        .t_idx        (t_idx),
        .flag_z       (bus.flag_z),
        .flag_n       (bus.flag_n),
        .control_word (uc_cw),
        .last         (uc_last),
        .illegal      (uc_illegal),
        .halt         (uc_halt)
    );

    // State register; reset aborts any instruction and leaves HALTED
    always_ff @(posedge clock) begin
        if (reset) state <= ST_T1;
        else       state <= state_next;
    end

    // Next state: hold in HALTED, enter it on HLT, otherwise wrap to T1 on
    // the last active T-state (early end) or on T_MAX-1 (padding)
    always_comb begin
        state_next = state;
        done       = 1'b0;
        if (state == ST_HALTED) begin
            state_next = ST_HALTED;
        end else if (uc_halt) begin
            state_next = ST_HALTED;
        end else if ((EARLY_END && uc_last) || (t_idx == T_LAST)) begin
            state_next = ST_T1;
            done       = 1'b1;
        end else begin
            state_next = state_t'(state + 4'd1);
        end
    end

    assign bus.control_word = reset               ? CW_NOP  :
                              (state == ST_HALTED) ? CW_HALT : uc_cw;
    assign bus.t_state      = (state == ST_HALTED) ? 3'd7 : t_idx;
    assign bus.instr_done   = !reset && done;
    assign bus.halted       = (state == ST_HALTED);
    assign bus.illegal_op   = !reset && (state != ST_HALTED) && uc_illegal;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed bench for sap_sequencer: one early-end instance (T_MAX=6) and one
// padded instance (T_MAX=8) driven with identical opcode/flag inputs.
module tb_sap_sequencer;

    localparam logic [15:0] NOP = 16'h3E3E;
    localparam int          T_MAX_P = 8;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        z;
        logic        n;
        int          ncyc;
        logic [15:0] x4;
        logic [15:0] x5;
        logic [15:0] x6;
        logic        ill;
    } vec_t;

    logic clock;
    logic rst_e;
    logic rst_p;
    int   tests;
    int   fails;
    vec_t vecs[13];

    sap_if bus_e();
    sap_if bus_p();

    sap_sequencer #(.EARLY_END(1'b1), .T_MAX(6)) dut_e (
        .clock (clock),
        .reset (rst_e),
        .bus   (bus_e)
    );

    sap_sequencer #(.EARLY_END(1'b0), .T_MAX(T_MAX_P)) dut_p (
        .clock (clock),
        .reset (rst_p),
        .bus   (bus_p)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] op, input logic z, input logic n);
        bus_e.instruction = op;
        bus_e.flag_z      = z;
        bus_e.flag_n      = n;
        bus_p.instruction = op;
        bus_p.flag_z      = z;
        bus_p.flag_n      = n;
    endtask

    // Called just after the edge that enters T1; returns just after the edge
    // that ends the instruction.
    task automatic apply(input vec_t v, input bit pad);
        int          nc;
        logic [15:0] exp_cw;
        logic [15:0] cw;
        logic [2:0]  ts;
        logic        dn;
        logic        il;
        logic        hl;
        nc = pad ? T_MAX_P : v.ncyc;
        set_in(v.op, v.z, v.n);
        for (int t = 0; t < nc; t++) begin
            @(negedge clock);
            case (t)
                0:       exp_cw = 16'h5E3E;
                1:       exp_cw = 16'hBE3E;
                2:       exp_cw = 16'h263E;
                3:       exp_cw = v.x4;
                4:       exp_cw = v.x5;
                5:       exp_cw = v.x6;
                default: exp_cw = NOP;
            endcase
            cw = pad ? bus_p.control_word : bus_e.control_word;
            ts = pad ? bus_p.t_state      : bus_e.t_state;
            dn = pad ? bus_p.instr_done   : bus_e.instr_done;
            il = pad ? bus_p.illegal_op   : bus_e.illegal_op;
            hl = pad ? bus_p.halted       : bus_e.halted;
            chk($sformatf("%s%s t%0d t_state", v.name, pad ? "/pad" : "", t), 16'(ts), 16'(t));
            chk($sformatf("%s%s t%0d cw", v.name, pad ? "/pad" : "", t), cw, exp_cw);
            chk($sformatf("%s%s t%0d done", v.name, pad ? "/pad" : "", t), 16'(dn), 16'(t == nc - 1));
            chk($sformatf("%s%s t%0d illegal", v.name, pad ? "/pad" : "", t), 16'(il), 16'(t == 3 && v.ill));
            chk($sformatf("%s%s t%0d halted", v.name, pad ? "/pad" : "", t), 16'(hl), 16'h0);
            if (t < nc - 1) begin
                @(posedge clock);
                #1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Stimulus and checks
    initial begin
        tests = 0;
        fails = 0;
        rst_e = 1'b1;
        rst_p = 1'b1;
        set_in(4'h0, 1'b0, 1'b0);

        vecs[0]  = '{"LDI",  4'h4, 1'b0, 1'b0, 4, 16'h383A, NOP,      NOP,      1'b0};
        vecs[1]  = '{"SUB",  4'h2, 1'b0, 1'b0, 6, 16'h1A3E, 16'h2E1E, 16'h3CFA, 1'b0};
        vecs[2]  = '{"ADD",  4'h1, 1'b0, 1'b0, 6, 16'h1A3E, 16'h2E1E, 16'h3C7A, 1'b0};
        vecs[3]  = '{"LDA",  4'h0, 1'b0, 1'b0, 5, 16'h1A3E, 16'h2C3A, NOP,      1'b0};
        vecs[4]  = '{"STA",  4'h3, 1'b0, 1'b0, 5, 16'h1A3E, 16'h3F3C, NOP,      1'b0};
        vecs[5]  = '{"JMP",  4'h5, 1'b0, 1'b0, 4, 16'h3A36, NOP,      NOP,      1'b0};
        vecs[6]  = '{"JZ1",  4'h6, 1'b1, 1'b0, 4, 16'h3A36, NOP,      NOP,      1'b0};
        vecs[7]  = '{"JZ0",  4'h6, 1'b0, 1'b1, 4, NOP,      NOP,      NOP,      1'b0};
        vecs[8]  = '{"JN1",  4'h7, 1'b0, 1'b1, 4, 16'h3A36, NOP,      NOP,      1'b0};
        vecs[9]  = '{"JN0",  4'h7, 1'b1, 1'b0, 4, NOP,      NOP,      NOP,      1'b0};
        vecs[10] = '{"OUT",  4'hE, 1'b0, 1'b0, 4, 16'h3F2E, NOP,      NOP,      1'b0};
        vecs[11] = '{"ILLA", 4'hA, 1'b0, 1'b0, 4, NOP,      NOP,      NOP,      1'b1};
        vecs[12] = '{"ILLD", 4'hD, 1'b1, 1'b1, 4, NOP,      NOP,      NOP,      1'b1};

        // Reset held two cycles
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset cw",      bus_e.control_word,       NOP);
        chk("reset t_state", 16'(bus_e.t_state),       16'h0);
        chk("reset halted",  16'(bus_e.halted),        16'h0);
        chk("reset done",    16'(bus_e.instr_done),    16'h0);
        chk("reset illegal", 16'(bus_e.illegal_op),    16'h0);
        chk("reset cw pad",  bus_p.control_word,       NOP);
        @(posedge clock);
        #1;
        rst_e = 1'b0;

        // Every opcode class through the early-end instance
        for (int i = 0; i < 13; i++) apply(vecs[i], 1'b0);

        // HLT, then 20 halted cycles under changing inputs
        set_in(4'hF, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clock);
            chk($sformatf("HLT t%0d t_state", t), 16'(bus_e.t_state), 16'(t));
            chk($sformatf("HLT t%0d done", t), 16'(bus_e.instr_done), 16'h0);
            if (t == 3) chk("HLT t3 cw", bus_e.control_word, 16'h3E3F);
            @(posedge clock);
            #1;
        end
        for (int c = 0; c < 20; c++) begin
            set_in(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clock);
            chk($sformatf("halted c%0d halted", c), 16'(bus_e.halted), 16'h1);
            chk($sformatf("halted c%0d t_state", c), 16'(bus_e.t_state), 16'h7);
            chk($sformatf("halted c%0d cw", c), bus_e.control_word, 16'h3E3F);
            chk($sformatf("halted c%0d done", c), 16'(bus_e.instr_done), 16'h0);
            @(posedge clock);
            #1;
        end
        rst_e = 1'b1;
        @(negedge clock);
        chk("halt reset cw", bus_e.control_word, NOP);
        @(posedge clock);
        #1;
        rst_e = 1'b0;
        apply(vecs[0], 1'b0);

        // Reset during T5 of ADD
        set_in(4'h1, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        rst_e = 1'b1;
        @(negedge clock);
        chk("abort t_state", 16'(bus_e.t_state),    16'h4);
        chk("abort cw",      bus_e.control_word,    NOP);
        chk("abort done",    16'(bus_e.instr_done), 16'h0);
        @(posedge clock);
        #1;
        rst_e = 1'b0;
        apply(vecs[0], 1'b0);

        // Padded instance, T_MAX=8
        rst_e = 1'b1;
        rst_p = 1'b0;
        apply(vecs[1], 1'b1);
        apply(vecs[0], 1'b1);
        apply(vecs[6], 1'b1);
        apply(vecs[11], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sap_sequencer.md
Name: sap_sequencer

Overview:
Parametrised microprogram sequencer for the SAP CPU datapath. It is the successor to the fixed six-state controller.
- Adds a synchronous reset, a latched halt and a 16-bit control word (store, PC load, flags load, halt).
- Adds immediate load, and unconditional plus conditional jumps on Z/N flags.
- Has a selectable mode that ends instructions early instead of padding the cycle with NOPs.
- Sits between the IR/flags register and every datapath load/enable strobe.

Parameters:
EARLY_END, 1, 1 = jump to T1 after an instruction's last active T-state; 0 = pad with NOP up to T_MAX.
T_MAX, 6, number of T-states per instruction when EARLY_END=0; legal range 6..8 (elaboration error otherwise).

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
instruction  input  4  IR opcode nibble; valid from T4 onward, ignored in T1..T3
flag_z  input  1  zero flag, sampled combinationally in T4
flag_n  input  1  negative flag, sampled combinationally in T4
control_word  output  16  datapath strobes, bit order below
t_state  output  3  current T-state index, 0 = T1; 7 while halted
instr_done  output  1  high during the last T-state of each instruction (including NOP padding)
halted  output  1  high after HLT executes, until reset
illegal_op  output  1  high during T4 of an undefined opcode

Behaviour:
- Control word bits:
  - 15 Cp, 14 Ep, 13 Lm_n, 12 CE_n, 11 Li_n, 10 Ei_n, 9 La_n, 8 Ea.
  - 7 Su, 6 Eu, 5 Lb_n, 4 Lo_n, 3 Lp_n, 2 Lf_n, 1 We_n, 0 Hlt.
  - Bits named _n are active-low.
- CW_NOP = 16'h3E3E (all strobes inactive).
- Reset:
  - t_state = 0; halted = 0; instr_done = 0; illegal_op = 0.
  - control_word is forced to CW_NOP while reset is high.
  - Reset aborts any instruction in progress and clears the halted state.
- Fetch, identical for all opcodes:
  - T1 = Ep, Lm_n → 16'h5E3E.
  - T2 = Cp → 16'hBE3E.
  - T3 = CE_n, Li_n → 16'h263E.
- Execute:
  - LDA 0000: T4 Ei_n, Lm_n; T5 CE_n, La_n, Lf_n. Last = T5.
  - ADD 0001: T4 Ei_n, Lm_n; T5 CE_n, Lb_n; T6 Eu, La_n, Lf_n. Last = T6.
  - SUB 0010: as ADD, plus Su in T6 (T6 = 16'h3CFA).
  - STA 0011: T4 Ei_n, Lm_n; T5 Ea, We_n. Last = T5.
  - LDI 0100: T4 Ei_n, La_n, Lf_n (16'h383A). Last = T4.
  - JMP 0101: T4 Ei_n, Lp_n (16'h3A36). Last = T4.
  - JZ 0110: T4 = 16'h3A36 if flag_z, else CW_NOP. Last = T4.
  - JN 0111: as JZ, gated by flag_n instead.
  - OUT 1110: T4 Ea, Lo_n (16'h3F2E). Last = T4.
  - HLT 1111: T4 = 16'h3E3F. Next state is HALTED.
  - Any other opcode: T4 = CW_NOP and illegal_op = 1. Last = T4.
- State transitions:
  - EARLY_END=1: on the last active T-state, next state is T1.
  - EARLY_END=0: states after the last active one output CW_NOP; T_MAX−1 is last, then T1.
  - instr_done is high exactly on the state whose successor is T1.
- Cycle counts with EARLY_END=1: LDI/JMP/JZ/JN/OUT/illegal = 4; LDA/STA = 5; ADD/SUB = 6.
- HALTED:
  - control_word = 16'h3E3F, halted = 1, t_state = 7.
  - instruction and flag inputs are ignored; only reset leaves HALTED.
- instruction is decoded live in T4..T6; it must be stable from T4 to the end of the instruction. Flags matter only in T4.

Decomposition:
- Package sap_pkg:
  - opcode localparams.
  - control-word bit indices.
  - CW_NOP, CW_HLT.
  - state enum T1..T8 plus HALTED.
- Sub-module sap_microcode (combinational): inputs opcode, t-state, flags; outputs control word, last flag, illegal flag.
- Top-level sap_sequencer: state register, early-end/padding logic, halt latch, reset forcing.

Test Plan:
- Reset held 2 cycles, then released with instruction=0100 (LDI), EARLY_END=1 → control_word 16'h5E3E, 16'hBE3E, 16'h263E, 16'h383A with instr_done=1 in the 4th cycle; then t_state=0 again.
- SUB with EARLY_END=1 → T6 control_word 16'h3CFA, instr_done=1, next t_state=0. Same SUB with EARLY_END=0, T_MAX=8 → T7/T8 are 16'h3E3E and instr_done is high only in T8.
- JZ: flag_z=1 → T4 16'h3A36; flag_z=0 → T4 16'h3E3E. JN exercised the same way with flag_n; both end after 4 cycles.
- HLT → T4 16'h3E3F, then halted=1 and t_state=7 held for 20 cycles despite opcode and flag changes. reset=1 for 1 cycle → t_state=0, halted=0, fetch resumes.
- Opcode 1010 → illegal_op=1 only in T4, control_word 16'h3E3E, back to T1 after 4 cycles. OUT → T4 16'h3F2E.
- reset asserted during T5 of ADD → control_word 16'h3E3E that cycle, next t_state=0, and no T6 strobes are emitted.
